// File: rtl/pl_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF, MEM), the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the environment's view.
interface pl_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  stall_if, stall_mem, busy
  );
endinterface

// File: rtl/pl_mem_arbiter.sv
// Single-port memory arbiter for the IF and MEM pipeline stages: IDLE -> ACCESS (WAIT_CYC
// cycles) -> RESP (one-cycle ack), round-robin on contention, combinational stalls.
module pl_mem_arbiter #(
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  pl_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_owner;
  owner_t           grant;
  logic [CNT_W-1:0] cnt;

  // On contention the requester that did not win last time gets the memory.
  always_comb begin
    grant = OWN_IF;
    if (bus.if_req && bus.mem_req)
      grant = (last_owner == OWN_IF) ? OWN_MEM : OWN_IF;
    else if (bus.mem_req)
      grant = OWN_MEM;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      last_owner    <= OWN_IF;
      cnt           <= '0;
      bus.if_ack    <= 1'b0;
      bus.mem_ack   <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.if_req || bus.mem_req) begin
            state        <= ACCESS;
            owner        <= grant;
            last_owner   <= grant;
            cnt          <= CNT_W'(WAIT_CYC);
            bus.ram_en   <= 1'b1;
            bus.ram_we   <= (grant == OWN_MEM) && bus.mem_we;
            bus.ram_addr <= (grant == OWN_MEM) ? bus.mem_addr : bus.if_addr;
            if (grant == OWN_MEM)
              bus.ram_wdata <= bus.mem_wdata;
          end
        end

        ACCESS: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state      <= RESP;
            bus.ram_en <= 1'b0;
            bus.ram_we <= 1'b0;
            if (owner == OWN_MEM) bus.mem_ack <= 1'b1;
            else                  bus.if_ack  <= 1'b1;
            // ram_rdata is only valid on the last access cycle; writes leave rdata alone.
            if (!bus.ram_we) begin
              if (owner == OWN_MEM) bus.mem_rdata <= bus.ram_rdata;
              else                  bus.if_rdata  <= bus.ram_rdata;
            end
          end
        end

        RESP: begin
          // Unconditional return to IDLE keeps the owner's still-high req from re-granting.
          state       <= IDLE;
          bus.if_ack  <= 1'b0;
          bus.mem_ack <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_mem = bus.mem_req & ~bus.mem_ack;
  assign bus.stall_if  = (bus.if_req & ~bus.if_ack) | bus.stall_mem;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Bench for pl_mem_arbiter: two instances (WAIT_CYC=2 and 1) checked every cycle against a
// transaction-age model, plus directed scenarios with literal expectations.
module tb_pl_mem_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
  } drv_t;

  typedef struct packed {
    logic        if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem, busy;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  } obs_t;

  // A transaction is described by its age: 1..W are access cycles, W+1 is the ack cycle.
  typedef struct {
    bit          active;
    int          age;
    bit          own;   // 0 = IF, 1 = MEM
    bit          last;
    bit          we;
    logic [31:0] addr, wdata, if_rd, mem_rd;
  } mdl_t;

  drv_t d[2];
  mdl_t m[2];
  int   wc[2] = '{2, 1};

  int n_cmp = 0;
  int n_bad = 0;

  pl_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  pl_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  assign b0.if_req    = d[0].if_req;
  assign b0.if_addr   = d[0].if_addr;
  assign b0.mem_req   = d[0].mem_req;
  assign b0.mem_we    = d[0].mem_we;
  assign b0.mem_addr  = d[0].mem_addr;
  assign b0.mem_wdata = d[0].mem_wdata;
  assign b0.ram_rdata = d[0].ram_rdata;

  assign b1.if_req    = d[1].if_req;
  assign b1.if_addr   = d[1].if_addr;
  assign b1.mem_req   = d[1].mem_req;
  assign b1.mem_we    = d[1].mem_we;
  assign b1.mem_addr  = d[1].mem_addr;
  assign b1.mem_wdata = d[1].mem_wdata;
  assign b1.ram_rdata = d[1].ram_rdata;

  pl_mem_arbiter #(.WAIT_CYC(2)) dut0 (.clk(clk), .rst(d[0].rst), .bus(b0));
  pl_mem_arbiter #(.WAIT_CYC(1)) dut1 (.clk(clk), .rst(d[1].rst), .bus(b1));

  function automatic obs_t get_obs(int k);
    obs_t a;
    if (k == 0) begin
      a.if_ack = b0.if_ack;     a.mem_ack = b0.mem_ack;     a.ram_en = b0.ram_en;
      a.ram_we = b0.ram_we;     a.stall_if = b0.stall_if;   a.stall_mem = b0.stall_mem;
      a.busy = b0.busy;         a.if_rdata = b0.if_rdata;   a.mem_rdata = b0.mem_rdata;
      a.ram_addr = b0.ram_addr; a.ram_wdata = b0.ram_wdata;
    end else begin
      a.if_ack = b1.if_ack;     a.mem_ack = b1.mem_ack;     a.ram_en = b1.ram_en;
      a.ram_we = b1.ram_we;     a.stall_if = b1.stall_if;   a.stall_mem = b1.stall_mem;
      a.busy = b1.busy;         a.if_rdata = b1.if_rdata;   a.mem_rdata = b1.mem_rdata;
      a.ram_addr = b1.ram_addr; a.ram_wdata = b1.ram_wdata;
    end
    return a;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[inst%0d] @%0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_step(int k);
    bit g;
    if (!d[k].rst) begin
      m[k].active = 0; m[k].age = 0; m[k].own = 0; m[k].last = 0; m[k].we = 0;
      m[k].addr = '0; m[k].wdata = '0; m[k].if_rd = '0; m[k].mem_rd = '0;
    end else if (m[k].active) begin
      if (m[k].age == wc[k] && !m[k].we) begin
        if (m[k].own) m[k].mem_rd = d[k].ram_rdata;
        else          m[k].if_rd  = d[k].ram_rdata;
      end
      if (m[k].age == wc[k] + 1) m[k].active = 0;
      else                       m[k].age++;
    end else if (d[k].if_req || d[k].mem_req) begin
      g = (d[k].if_req && d[k].mem_req) ? !m[k].last : d[k].mem_req;
      m[k].active = 1;
      m[k].age    = 1;
      m[k].own    = g;
      m[k].last   = g;
      m[k].addr   = g ? d[k].mem_addr : d[k].if_addr;
      m[k].we     = g && d[k].mem_we;
      if (g) m[k].wdata = d[k].mem_wdata;
    end
  endtask

  function automatic bit exp_ack(int k, bit who);
    return m[k].active && (m[k].age == wc[k] + 1) && (m[k].own == who);
  endfunction

  task automatic compare(int k);
    obs_t a = get_obs(k);
    bit   en  = m[k].active && (m[k].age <= wc[k]);
    bit   eia = exp_ack(k, 1'b0);
    bit   ema = exp_ack(k, 1'b1);
    bit   esm = d[k].mem_req & ~ema;
    check("ram_en",    k, 32'(a.ram_en),    32'(en));
    check("ram_we",    k, 32'(a.ram_we),    32'(en && m[k].we));
    check("if_ack",    k, 32'(a.if_ack),    32'(eia));
    check("mem_ack",   k, 32'(a.mem_ack),   32'(ema));
    check("busy",      k, 32'(a.busy),      32'(m[k].active));
    check("stall_mem", k, 32'(a.stall_mem), 32'(esm));
    check("stall_if",  k, 32'(a.stall_if),  32'((d[k].if_req & ~eia) | esm));
    check("ram_addr",  k, a.ram_addr,  m[k].addr);
    check("ram_wdata", k, a.ram_wdata, m[k].wdata);
    check("if_rdata",  k, a.if_rdata,  m[k].if_rd);
    check("mem_rdata", k, a.mem_rdata, m[k].mem_rd);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    @(negedge clk);
    for (int k = 0; k < 2; k++) compare(k);
  endtask

  task automatic drive_random(int k);
    bool_rand: begin
      d[k].rst       = ($urandom_range(0, 199) != 0);
      d[k].ram_rdata = $urandom;
      if (d[k].if_req) begin
        if (exp_ack(k, 1'b0)) begin
          d[k].if_req  = $urandom_range(0, 1);
          d[k].if_addr = $urandom;
        end else if ($urandom_range(0, 49) == 0) begin
          d[k].if_req = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          d[k].if_addr = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d[k].if_req  = 1'b1;
        d[k].if_addr = $urandom;
      end
      if (d[k].mem_req) begin
        if (exp_ack(k, 1'b1)) begin
          d[k].mem_req   = $urandom_range(0, 1);
          d[k].mem_we    = $urandom_range(0, 1);
          d[k].mem_addr  = $urandom;
          d[k].mem_wdata = $urandom;
        end else if ($urandom_range(0, 49) == 0) begin
          d[k].mem_req = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          d[k].mem_we    = $urandom_range(0, 1);
          d[k].mem_wdata = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d[k].mem_req   = 1'b1;
        d[k].mem_we    = $urandom_range(0, 1);
        d[k].mem_addr  = $urandom;
        d[k].mem_wdata = $urandom;
      end
    end
  endtask

  initial begin
    obs_t a;
    for (int k = 0; k < 2; k++) begin
      d[k] = '0;
      d[k].if_req  = 1'b1;
      d[k].mem_req = 1'b1;
    end

    // Reset held with both requests high.
    repeat (3) cycle();
    a = get_obs(0);
    check("t1_ram_en",    0, 32'(a.ram_en),    32'd0);
    check("t1_acks",      0, 32'({a.if_ack, a.mem_ack}), 32'd0);
    check("t1_busy",      0, 32'(a.busy),      32'd0);
    check("t1_if_rdata",  0, a.if_rdata,       32'h0);
    check("t1_ram_wdata", 0, a.ram_wdata,      32'h0);
    check("t1_stall_if",  0, 32'(a.stall_if),  32'd1);
    check("t1_stall_mem", 0, 32'(a.stall_mem), 32'd1);

    for (int k = 0; k < 2; k++) begin
      d[k].rst = 1'b1; d[k].if_req = 1'b0; d[k].mem_req = 1'b0;
    end
    cycle();

    // Lone IF read, WAIT_CYC=2.
    d[0].if_req = 1'b1; d[0].if_addr = 32'h40; d[0].ram_rdata = 32'h8C010004;
    #1;
    check("t2_stall_if_c0", 0, 32'(b0.stall_if), 32'd1);
    cycle(); a = get_obs(0);
    check("t2_ram_en_c1",   0, 32'(a.ram_en),   32'd1);
    check("t2_ram_addr_c1", 0, a.ram_addr,      32'h40);
    cycle(); a = get_obs(0);
    check("t2_ram_en_c2",   0, 32'(a.ram_en),   32'd1);
    check("t2_if_ack_c2",   0, 32'(a.if_ack),   32'd0);
    cycle(); a = get_obs(0);
    check("t2_if_ack_c3",   0, 32'(a.if_ack),   32'd1);
    check("t2_if_rdata_c3", 0, a.if_rdata,      32'h8C010004);
    check("t2_stall_if_c3", 0, 32'(a.stall_if), 32'd0);
    d[0].if_req = 1'b0;
    cycle();

    // MEM store, WAIT_CYC=2.
    d[0].mem_req = 1'b1; d[0].mem_we = 1'b1;
    d[0].mem_addr = 32'h100; d[0].mem_wdata = 32'hDEADBEEF;
    cycle(); a = get_obs(0);
    check("t3_ram_we_c1",    0, 32'(a.ram_we),    32'd1);
    check("t3_ram_wdata_c1", 0, a.ram_wdata,      32'hDEADBEEF);
    check("t3_stall_c1",     0, 32'({a.stall_if, a.stall_mem}), 32'd3);
    cycle(); a = get_obs(0);
    check("t3_ram_we_c2",    0, 32'(a.ram_we),    32'd1);
    cycle(); a = get_obs(0);
    check("t3_mem_ack_c3",   0, 32'(a.mem_ack),   32'd1);
    check("t3_mem_rdata_c3", 0, a.mem_rdata,      32'h0);
    d[0].mem_req = 1'b0; d[0].mem_we = 1'b0;
    cycle();

    // Contention after reset: MEM first, then IF, then MEM again.
    d[0].rst = 1'b0;
    cycle();
    d[0].rst = 1'b1;
    d[0].if_req = 1'b1; d[0].mem_req = 1'b1;
    d[0].if_addr = 32'h200; d[0].mem_addr = 32'h300;
    cycle(); a = get_obs(0);
    check("t4_ram_addr_c1", 0, a.ram_addr, 32'h300);
    cycle();
    cycle(); a = get_obs(0);
    check("t4_mem_ack_c3",  0, 32'(a.mem_ack), 32'd1);
    d[0].mem_req = 1'b0;
    cycle(); a = get_obs(0);
    check("t4_busy_c4",     0, 32'(a.busy), 32'd0);
    cycle(); a = get_obs(0);
    check("t4_ram_addr_c5", 0, a.ram_addr, 32'h200);
    cycle();
    cycle(); a = get_obs(0);
    check("t4_if_ack_c7",   0, 32'(a.if_ack), 32'd1);
    d[0].if_req = 1'b0;
    cycle();
    d[0].if_req = 1'b1; d[0].mem_req = 1'b1;
    cycle(); a = get_obs(0);
    check("t4_regrant_mem", 0, a.ram_addr, 32'h300);
    cycle();
    cycle();
    d[0].if_req = 1'b0; d[0].mem_req = 1'b0;
    cycle();

    // Reset during the last access cycle of a MEM load.
    d[0].mem_req = 1'b1; d[0].mem_we = 1'b0; d[0].mem_addr = 32'h44;
    cycle();
    cycle();
    d[0].rst = 1'b0; d[0].if_req = 1'b1;
    cycle(); a = get_obs(0);
    check("t5_ram_en_c3",  0, 32'(a.ram_en),  32'd0);
    check("t5_mem_ack_c3", 0, 32'(a.mem_ack), 32'd0);
    d[0].rst = 1'b1;
    cycle(); a = get_obs(0);
    check("t5_mem_first",  0, a.ram_addr, 32'h44);
    cycle();
    cycle(); a = get_obs(0);
    check("t5_mem_ack",    0, 32'(a.mem_ack), 32'd1);
    d[0].if_req = 1'b0; d[0].mem_req = 1'b0;
    cycle();

    // Back-to-back IF fetches with WAIT_CYC=1: period of three cycles.
    d[1].if_req = 1'b1; d[1].if_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cycle(); a = get_obs(1);
      check("t6_ram_addr", 1, a.ram_addr, 32'(i * 4));
      cycle(); a = get_obs(1);
      check("t6_if_ack",   1, 32'(a.if_ack), 32'd1);
      d[1].if_addr = 32'((i + 1) * 4);
      if (i < 2) begin
        cycle(); a = get_obs(1);
        check("t6_gap",    1, 32'(a.if_ack), 32'd0);
      end
    end
    d[1].if_req = 1'b0;
    cycle();

    // Randomized traffic on both instances.
    repeat (3000) begin
      for (int k = 0; k < 2; k++) drive_random(k);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pl_mem_arbiter.md
Name: pl_mem_arbiter

Overview:
Arbitrates the single-ported unified instruction/data memory of the 5-stage MIPS pipeline between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store). It sequences each multi-cycle memory access through a small FSM and raises pipeline stall signals while a requester waits. The block sits between the CPU_pl pipeline registers and the memory macro.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
WAIT_CYC, 2, memory access latency in cycles; legal range >= 1 (0 is illegal)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
if_req  in  1  IF fetch request; level, held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse for IF
if_rdata  out  DATA_W  fetched instruction, registered
mem_req  in  1  MEM request; level, held until mem_ack
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_ack  out  1  one-cycle completion pulse for MEM
mem_rdata  out  DATA_W  load data, registered
ram_en  out  1  memory enable
ram_we  out  1  memory write enable
ram_addr  out  ADDR_W  memory address, latched
ram_wdata  out  DATA_W  memory write data, latched
ram_rdata  in  DATA_W  memory read data, valid on the last ACCESS cycle
stall_if  out  1  freeze PC and IF/ID
stall_mem  out  1  freeze the whole pipeline
busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Registers: owner (IF/MEM), last_owner, cnt (width clog2(WAIT_CYC+1)).
- Reset (rst=0 at an edge): state=IDLE, owner=IF, last_owner=IF, cnt=0. All registered outputs are 0: if_ack, mem_ack, ram_en, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata. Reset overrides every other event.
- IDLE to ACCESS, when any req is high:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_owner. After reset, MEM wins first.
  - On the transition edge: latch addr and wdata into ram_addr/ram_wdata; set owner; last_owner <= granted requester; cnt <= WAIT_CYC.
- ACCESS:
  - ram_en=1 for exactly WAIT_CYC cycles.
  - ram_we=1 for the same cycles iff owner=MEM and the latched mem_we=1.
  - cnt decrements each cycle. On the edge leaving the cycle where cnt==1, go to RESP.
  - On a read, that same edge captures ram_rdata into the owner's rdata register. On a write, both rdata registers are unchanged.
- RESP: the owner's ack=1 for exactly this cycle; ram_en=ram_we=0. Go to IDLE unconditionally. This inserts one bubble so the owner's still-high req is not re-granted.
- Latency: req first high in cycle 0 (FSM idle) gives ACCESS in cycles 1..WAIT_CYC and ack in cycle WAIT_CYC+1. Back-to-back period per requester is WAIT_CYC+2.
- Requester input changes during ACCESS are ignored (latched values are used).
- If req drops before ack (protocol violation), the access still completes and ack still pulses.
- Stalls are combinational:
  - stall_mem = mem_req & ~mem_ack
  - stall_if = (if_req & ~if_ack) | stall_mem
- busy = (state != IDLE).
- Reset mid-ACCESS or mid-RESP aborts the access: no ack is issued and ram_en is 0 from the following cycle.

Test Plan:
1. Hold rst=0 for 3 cycles with if_req=1, mem_req=1 -> ram_en=0, if_ack=mem_ack=0, busy=0, all data outputs 0. stall_if=stall_mem=1 (combinational).
2. WAIT_CYC=2; lone IF read, if_addr=0x00000040, ram_rdata=0x8C010004 -> ram_en=1, ram_addr=0x40 in cycles 1-2. if_ack=1 in cycle 3 only, if_rdata=0x8C010004. stall_if=1 in cycles 0-2 and 0 in cycle 3.
3. WAIT_CYC=2; MEM store, mem_addr=0x100, mem_wdata=0xDEADBEEF -> ram_we=1 with ram_wdata=0xDEADBEEF in cycles 1-2. mem_ack in cycle 3. stall_mem and stall_if =1 in cycles 0-2. mem_rdata unchanged.
4. After reset, if_req and mem_req both rise in cycle 0 -> MEM is served (ACCESS 1-2, mem_ack 3). IF is granted in cycle 4 (ACCESS 5-6, if_ack 7). A following simultaneous request is granted to MEM first.
5. rst=0 asserted in cycle 2 of a MEM access -> no mem_ack, ram_en=0 from cycle 3. After rst=1 with both requesting, MEM is granted first (last_owner reset to IF).
6. WAIT_CYC=1; IF re-requests immediately after each ack with addresses 0x0, 0x4, 0x8 -> if_ack in cycles 2, 5, 8. ram_addr sequence is 0x0, 0x4, 0x8.
